// File: rtl/adc_scan_ctrl.sv
// ============================================================================
// Module   : adc_scan_ctrl
// Sequencer for an 8-channel ALE/START/EOC/OE converter: channel scan or
// single shot, EOC blanking and timeout, result bank with valid bits.
// Optional feature macro: ADC_SCAN_FILT_EN (rounded running average on store)
// Revision : 1.0
// ============================================================================
`default_nettype none

module adc_scan_ctrl #(
   parameter int START_W      = 2,
   parameter int EOC_BLANK    = 4,
   parameter int CONV_TIMEOUT = 1024,
   parameter int OE_W         = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       enable,
   input  logic [7:0] chan_mask,
   input  logic       req,
   input  logic [2:0] req_chan,
   output logic [2:0] addr,
   output logic       ale,
   output logic       start,
   output logic       oe,
   input  logic [7:0] adc_data,
   input  logic       eoc,
   input  logic [2:0] rd_chan,
   output logic [7:0] rd_data,
   output logic [7:0] valid,
   output logic       busy,
   output logic       done,
   output logic [2:0] done_chan,
   output logic       timeout_err
);

   localparam int MAX_A = (START_W > OE_W) ? START_W : OE_W;
   localparam int MAX_B = (EOC_BLANK > CONV_TIMEOUT) ? EOC_BLANK : CONV_TIMEOUT;
   localparam int MAX_C = (MAX_A > MAX_B) ? MAX_A : MAX_B;
   localparam int CNT_W = $clog2(MAX_C + 1);

   localparam logic [CNT_W-1:0] START_LAST = CNT_W'(START_W - 1);
   localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(EOC_BLANK - 1);
   localparam logic [CNT_W-1:0] TO_LAST    = CNT_W'(CONV_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] OE_LAST    = CNT_W'(OE_W - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_SETUP, S_ALE, S_START, S_BLANK, S_WAIT, S_READ, S_STORE
   } state_t;

   state_t           state, state_n;
   logic [CNT_W-1:0] cnt;
   logic             cnt_clr;
   logic             load_ch;
   logic [2:0]       sel_chan;
   logic             to_hit;
   logic [2:0]       ch;
   logic [2:0]       ptr;
   logic [7:0]       sample;
   logic [7:0]       result [8];
   logic [7:0]       store_val;

   logic             pick_found;
   logic [2:0]       pick_chan;
   logic [2:0]       idx;

   // First enabled channel at or above the scan pointer, wrapping 7 -> 0.
   always_comb begin
      pick_found = 1'b0;
      pick_chan  = ptr;
      idx        = '0;
      for (int i = 7; i >= 0; i--) begin
         idx = ptr + 3'(i);
         if (chan_mask[idx]) begin
            pick_found = 1'b1;
            pick_chan  = idx;
         end
      end
   end

   always_comb begin
      state_n  = state;
      load_ch  = 1'b0;
      sel_chan = req_chan;
      to_hit   = 1'b0;
      case (state)
         S_IDLE: begin
            if (enable && pick_found) begin
               state_n  = S_SETUP;
               load_ch  = 1'b1;
               sel_chan = pick_chan;
            end else if (req) begin
               state_n  = S_SETUP;
               load_ch  = 1'b1;
               sel_chan = req_chan;
            end
         end
         S_SETUP: state_n = S_ALE;
         S_ALE:   state_n = S_START;
         S_START: begin
            if (cnt == START_LAST)
               state_n = (EOC_BLANK == 0) ? S_WAIT : S_BLANK;
         end
         S_BLANK: begin
            if (cnt == BLANK_LAST)
               state_n = S_WAIT;
         end
         S_WAIT: begin
            if (eoc) begin
               state_n = S_READ;
            end else if (cnt == TO_LAST) begin
               state_n = S_IDLE;
               to_hit  = 1'b1;
            end
         end
         S_READ: begin
            if (cnt == OE_LAST)
               state_n = S_STORE;
         end
         S_STORE: state_n = S_IDLE;
         default: state_n = S_IDLE;
      endcase
      // The timeout count spans BLANK and WAIT, so that hand-off keeps counting.
      cnt_clr = (state == S_IDLE) ||
                ((state_n != state) && !(state == S_BLANK && state_n == S_WAIT));
   end

`ifdef ADC_SCAN_FILT_EN
   logic [8:0] filt_sum;
   assign filt_sum  = {1'b0, result[ch]} + {1'b0, sample} + 9'd1;
   assign store_val = valid[ch] ? filt_sum[8:1] : sample;
`else
   assign store_val = sample;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= S_IDLE;
         cnt         <= '0;
         ch          <= '0;
         ptr         <= '0;
         sample      <= '0;
         valid       <= '0;
         timeout_err <= 1'b0;
         for (int i = 0; i < 8; i++)
            result[i] <= '0;
      end else begin
         state <= state_n;
         cnt   <= cnt_clr ? '0 : cnt + 1'b1;
         if (load_ch)
            ch <= sel_chan;
         if (state == S_READ && cnt == OE_LAST)
            sample <= adc_data;
         if (to_hit) begin
            timeout_err <= 1'b1;
            ptr         <= ch + 3'd1;
         end
         if (state == S_STORE) begin
            result[ch]  <= store_val;
            valid[ch]   <= 1'b1;
            timeout_err <= 1'b0;
            ptr         <= ch + 3'd1;
         end
      end
   end

   assign addr      = ch;
   assign ale       = (state == S_ALE);
   assign start     = (state == S_START);
   assign oe        = (state == S_READ);
   assign busy      = (state != S_IDLE);
   assign done      = (state == S_STORE);
   assign done_chan = ch;
   assign rd_data   = result[rd_chan];

endmodule

`default_nettype wire

// File: tb/tb_adc_scan_ctrl.sv
// ============================================================================
// Module   : tb_adc_scan_ctrl
// Directed bench for adc_scan_ctrl with a converter model and result scoreboard.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_adc_scan_ctrl;

   localparam int START_W      = 2;
   localparam int EOC_BLANK    = 4;
   localparam int CONV_TIMEOUT = 1024;
   localparam int OE_W         = 2;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       enable = 1'b0;
   logic [7:0] chan_mask = 8'h00;
   logic       req = 1'b0;
   logic [2:0] req_chan = 3'd0;
   logic [2:0] rd_chan = 3'd0;
   logic [2:0] addr;
   logic       ale, start, oe;
   logic [7:0] adc_data;
   logic       eoc;
   logic [7:0] rd_data;
   logic [7:0] valid;
   logic       busy, done, timeout_err;
   logic [2:0] done_chan;

   logic       model_on = 1'b0;
   logic       m_eoc = 1'b0, t_eoc = 1'b0;
   logic [7:0] m_data = 8'h00, t_data = 8'h00;
   logic [7:0] conv_val [8];
   int         eoc_delay = 4;

   int          n_tests = 0;
   int          n_fail  = 0;
   int          cyc     = 0;
   logic [10:0] sb_q [$];
   logic [7:0]  exp_bank [8];
   logic [7:0]  exp_valid = 8'h00;

   assign eoc      = model_on ? m_eoc : t_eoc;
   assign adc_data = model_on ? m_data : t_data;

   adc_scan_ctrl #(
      .START_W(START_W), .EOC_BLANK(EOC_BLANK),
      .CONV_TIMEOUT(CONV_TIMEOUT), .OE_W(OE_W)
   ) dut (
      .clk(clk), .rst(rst), .enable(enable), .chan_mask(chan_mask),
      .req(req), .req_chan(req_chan), .addr(addr), .ale(ale),
      .start(start), .oe(oe), .adc_data(adc_data), .eoc(eoc),
      .rd_chan(rd_chan), .rd_data(rd_data), .valid(valid), .busy(busy),
      .done(done), .done_chan(done_chan), .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] stored(input logic [7:0] old, input logic v,
                                         input logic [7:0] s);
      logic [8:0] sum;
      sum = {1'b0, old} + {1'b0, s} + 9'd1;
`ifdef ADC_SCAN_FILT_EN
      return v ? sum[8:1] : s;
`else
      return (v && sum[0]) ? s : s;
`endif
   endfunction

   // Converter model: eoc rises eoc_delay cycles after start falls.
   initial begin
      forever begin
         @(negedge clk);
         if (model_on && start) begin
            do @(negedge clk); while (start);
            for (int i = 0; i < eoc_delay; i++) @(negedge clk);
            m_data = conv_val[addr];
            m_eoc  = 1'b1;
            for (int i = 0; i < 64 && !oe; i++) @(negedge clk);
            m_eoc  = 1'b0;
         end
      end
   end

   // Called at the negedge of a done cycle: scoreboard pop and bank checks.
   task automatic sb_check();
      logic [10:0] e;
      logic [7:0]  nv;
      chk("sb_nonempty", 32'(sb_q.size() > 0), 1);
      if (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         chk("done_chan", done_chan, e[10:8]);
         nv = stored(exp_bank[e[10:8]], exp_valid[e[10:8]], e[7:0]);
         rd_chan = e[10:8];
         #1;
         chk("rd_old_same_cycle", rd_data, exp_bank[e[10:8]]);
         exp_bank[e[10:8]]  = nv;
         exp_valid[e[10:8]] = 1'b1;
         @(negedge clk);
         chk("rd_new", rd_data, nv);
         chk("valid", valid, exp_valid);
      end
   endtask

   task automatic wait_done(input int budget, output int at_cyc);
      bit got;
      got = 1'b0;
      for (int n = 0; n < budget && !got; n++) begin
         @(negedge clk);
         chk("ctl_excl", 32'({ale, start, oe} inside {3'b000, 3'b001, 3'b010, 3'b100}), 1);
         if ((ale || start) && sb_q.size() > 0)
            chk("addr", addr, sb_q[0][10:8]);
         if (done) got = 1'b1;
      end
      at_cyc = cyc;
      chk("done_seen", 32'(got), 1);
      if (got) sb_check();
   endtask

   task automatic shot(input logic [2:0] ch, input logic [7:0] d, input bit push,
                       output int c0);
      conv_val[ch] = d;
      if (push) sb_q.push_back({ch, d});
      @(negedge clk);
      req = 1'b1;
      req_chan = ch;
      c0 = cyc;
      @(negedge clk);
      req = 1'b0;
   endtask

   task automatic wait_start_fall();
      for (int k = 0; k < 20 && !start; k++) @(negedge clk);
      for (int k = 0; k < 20 && start; k++) @(negedge clk);
   endtask

   initial begin
      int c0, at, prev, first_oe, oe_cnt, done_k;
      bit seen;
      logic [7:0] v_before;
      for (int i = 0; i < 8; i++) begin
         conv_val[i] = 8'h00;
         exp_bank[i] = 8'h00;
      end

      // Reset state
      repeat (2) @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_ctl", {ale, start, oe}, 0);
      chk("rst_done", done, 0);
      chk("rst_valid", valid, 0);
      chk("rst_timeout", timeout_err, 0);
      chk("rst_addr", addr, 0);
      chk("rst_rd", rd_data, 0);
      rst = 1'b0;

      // Single shot, channel 5, fixed latency
      model_on = 1'b1;
      shot(3'd5, 8'hA7, 1'b1, c0);
      wait_done(40, at);
      chk("shot_latency", at - c0, 12);

      // Reset in the middle of WAIT
      model_on = 1'b0;
      t_eoc = 1'b0;
      shot(3'd3, 8'h00, 1'b0, c0);
      repeat (10) @(negedge clk);
      chk("pre_rst_busy", busy, 1);
      rst = 1'b1;
      @(negedge clk);
      chk("mid_rst_ctl", {ale, start, oe}, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_valid", valid, 0);
      for (int i = 0; i < 8; i++) begin
         rd_chan = 3'(i);
         #1;
         chk("mid_rst_rd", rd_data, 0);
         exp_bank[i] = 8'h00;
      end
      exp_valid = 8'h00;
      rst = 1'b0;

      // Continuous scan of 0x91; same-cycle req must be dropped
      model_on = 1'b1;
      conv_val[0] = 8'h10;
      conv_val[4] = 8'h40;
      conv_val[7] = 8'h70;
      sb_q.push_back({3'd0, 8'h10});
      sb_q.push_back({3'd4, 8'h40});
      sb_q.push_back({3'd7, 8'h70});
      sb_q.push_back({3'd0, 8'h10});
      sb_q.push_back({3'd4, 8'h40});
      @(negedge clk);
      enable = 1'b1;
      chan_mask = 8'h91;
      req = 1'b1;
      req_chan = 3'd2;
      @(negedge clk);
      req = 1'b0;
      prev = 0;
      for (int i = 0; i < 5; i++) begin
         wait_done(60, at);
         if (i > 0) chk("scan_gap", at - prev, 13);
         prev = at;
      end
      enable = 1'b0;
      @(negedge clk);
      chk("scan_stop_busy", busy, 0);
      chk("scan_sb_empty", sb_q.size(), 0);

      // Conversion timeout on channel 4
      model_on = 1'b0;
      t_eoc = 1'b0;
      v_before = exp_valid;
      shot(3'd4, 8'h00, 1'b0, c0);
      wait_start_fall();
      seen = 1'b0;
      repeat (CONV_TIMEOUT - 1) begin
         @(negedge clk);
         if (done) seen = 1'b1;
      end
      chk("to_not_yet", timeout_err, 0);
      chk("to_busy", busy, 1);
      @(negedge clk);
      chk("to_set", timeout_err, 1);
      chk("to_idle", busy, 0);
      chk("to_no_done", 32'(seen), 0);
      chk("to_valid", valid, v_before);

      // Next good conversion clears the sticky error
      model_on = 1'b1;
      shot(3'd0, 8'h33, 1'b1, c0);
      wait_done(40, at);
      chk("to_cleared", timeout_err, 0);

      // EOC blanking: early eoc ignored, real eoc at cycle 20
      model_on = 1'b0;
      shot(3'd1, 8'h5C, 1'b1, c0);
      wait_start_fall();
      first_oe = -1;
      oe_cnt = 0;
      done_k = -1;
      for (int k = 0; k < 40; k++) begin
         if (k == 0) t_eoc = 1'b1;
         if (k == 4) t_eoc = 1'b0;
         if (k == 20) begin
            t_eoc  = 1'b1;
            t_data = 8'h5C;
         end
         #1;
         if (oe) begin
            if (first_oe < 0) first_oe = k;
            oe_cnt++;
         end
         if (done) begin
            done_k = k;
            break;
         end
         @(negedge clk);
      end
      chk("blank_first_oe", first_oe, 21);
      chk("blank_oe_width", oe_cnt, OE_W);
      chk("blank_done_k", done_k, 23);
      if (done_k >= 0) sb_check();
      t_eoc = 1'b0;

      // Two samples on channel 2 (averaged when the filter is built in)
      model_on = 1'b1;
      shot(3'd2, 8'h80, 1'b1, c0);
      wait_done(40, at);
      shot(3'd2, 8'h03, 1'b1, c0);
      wait_done(40, at);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
